// File: rtl/mul_share_arbiter.sv
//------------------------------------------------------------------------------
// mul_share_arbiter : round-robin sharing of one pipelined multiplier,
//                     tagging each op so its result returns to its issuer.
// Revision 1.0
//------------------------------------------------------------------------------
`default_nettype none

module mul_share_arbiter #(
  parameter int DATA_WIDTH  = 16,
  parameter int BIN_POS     = 8,
  parameter int NUM_REQ     = 4,
  parameter int MUL_LATENCY = 1
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic [NUM_REQ-1:0]            req_valid,
  output logic [NUM_REQ-1:0]            req_ready,
  input  logic [NUM_REQ*DATA_WIDTH-1:0] req_lhs,
  input  logic [NUM_REQ*DATA_WIDTH-1:0] req_rhs,
  output logic [DATA_WIDTH-1:0]         mul_lhs,
  output logic [DATA_WIDTH-1:0]         mul_rhs,
  input  logic [DATA_WIDTH-1:0]         mul_out,
  output logic [NUM_REQ-1:0]            rsp_valid,
  output logic [DATA_WIDTH-1:0]         rsp_data,
  output logic                          busy
);

  localparam int c_PTR_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

  // Binary point is the multiplier's concern; only its range is sanity-checked here.
  if (NUM_REQ < 1 || MUL_LATENCY < 1 || BIN_POS < 0 || BIN_POS >= DATA_WIDTH) begin : g_bad_params
    $error("mul_share_arbiter: illegal parameter combination");
  end

  logic [c_PTR_W-1:0]                   r_rr_ptr;
  logic [MUL_LATENCY:0]                 r_vld;
  logic [MUL_LATENCY:0][c_PTR_W-1:0]    r_tag;

  logic                                 w_any;
  logic [c_PTR_W-1:0]                   w_gnt_idx;
  logic [c_PTR_W-1:0]                   w_nxt_ptr;

  function automatic int rr_idx(input logic [c_PTR_W-1:0] ptr, input int k);
    return (int'(ptr) + k) % NUM_REQ;
  endfunction

  // Descending scan so the requester closest to rr_ptr is the last (winning) write.
  always_comb begin
    w_any     = 1'b0;
    w_gnt_idx = '0;
    for (int k = NUM_REQ - 1; k >= 0; k--) begin
      if (req_valid[rr_idx(r_rr_ptr, k)]) begin
        w_any     = 1'b1;
        w_gnt_idx = c_PTR_W'(rr_idx(r_rr_ptr, k));
      end
    end
    if (rst) begin
      w_any = 1'b0;
    end
    w_nxt_ptr = c_PTR_W'((int'(w_gnt_idx) + 1) % NUM_REQ);
  end

  always_comb begin
    req_ready = '0;
    rsp_valid = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      req_ready[i] = w_any && (w_gnt_idx == c_PTR_W'(i));
      rsp_valid[i] = r_vld[MUL_LATENCY] && (r_tag[MUL_LATENCY] == c_PTR_W'(i));
    end
  end

  assign rsp_data = mul_out;
  assign busy     = |r_vld;

  // Tag pipe shifts unconditionally; operands and pointer only move on a transfer.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_rr_ptr <= '0;
      r_vld    <= '0;
      r_tag    <= '0;
      mul_lhs  <= '0;
      mul_rhs  <= '0;
    end else begin
      r_vld <= {r_vld[MUL_LATENCY-1:0], w_any};
      r_tag <= {r_tag[MUL_LATENCY-1:0], w_gnt_idx};
      if (w_any) begin
        mul_lhs  <= req_lhs[int'(w_gnt_idx)*DATA_WIDTH +: DATA_WIDTH];
        mul_rhs  <= req_rhs[int'(w_gnt_idx)*DATA_WIDTH +: DATA_WIDTH];
        r_rr_ptr <= w_nxt_ptr;
      end
    end
  end

endmodule

`default_nettype wire
